tt_analog_scan_ctrl: RTL and testbench

Digital sequencer for the analog front end on the `ua[5:0]` pins. It scans the enabled channels in order. For each channel it drives the analog mux select and track/hold, then runs an NBITS successive-approximation search against the analog core's comparator through the DAC code bus. Each result is published over a valid/ready handshake. The block sits between the analog macro and the digital I/O logic of the tile.

---
 rtl/tt_analog_pkg.sv | 24 ++
 rtl/tt_analog_cmp_sync.sv | 25 ++
 rtl/tt_analog_scan_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tt_analog_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_analog_pkg.sv
// Shared types and default constants for the analog scan controller.
//   scan_state_t : controller state encoding
//   NCH          : number of analog channels on ua[5:0]
//   NBITS        : SAR conversion resolution
//   SETTLE_CYC   : mux settle / track cycles per channel (>= 1)
//   CMP_WAIT     : cycles per SAR bit (>= 3, covers the comparator synchronizer)
//   CH_W         : channel index width
package tt_analog_pkg;

    localparam int NCH        = 6;
    localparam int NBITS      = 8;
    localparam int SETTLE_CYC = 4;
    localparam int CMP_WAIT   = 3;
    localparam int CH_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_CONVERT = 3'd3,
        ST_PUBLISH = 3'd4
    } scan_state_t;

endpackage

// File: rtl/tt_analog_cmp_sync.sv
// Two-flop synchronizer bringing the asynchronous comparator output into clk.
//   clk      : system clock
//   rst_n    : synchronous active-low reset, clears both flops
//   cmp_in   : asynchronous comparator output
//   cmp_sync : synchronized comparator, two cycles of latency
module tt_analog_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cmp_in,
    output logic cmp_sync
);

    logic cmp_meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_sync <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_sync <= cmp_meta;
        end
    end

endmodule

// File: rtl/tt_analog_scan_ctrl.sv
// Channel scan sequencer and SAR controller for the analog front end.
// Scans the enabled channels in ascending order; for each one it settles the
// mux in track mode, holds, runs an NBITS successive-approximation search via
// dac_code / cmp_in and publishes the result over a valid/ready handshake.
//   clk, rst_n          : clock, synchronous active-low reset
//   ena, abort          : tile enable (low = abort), abort request
//   start, continuous   : scan start pulse, auto-restart after last channel
//   ch_mask             : enabled channels, sampled at each scan start
//   cmp_in              : asynchronous comparator (1 when vin >= DAC level)
//   mux_sel, mux_en     : analog mux channel select and enable
//   sample              : track/hold, 1 = track
//   dac_code            : SAR trial code
//   busy                : controller not idle
//   res_valid/res_ready : result handshake; res_ch, res_data carry the result
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; mux off, DAC at zero
// ST_SETTLE  | mux on, tracking the selected channel for SETTLE_CYC cycles
// ST_HOLD    | one hold cycle; loads the first trial code
// ST_CONVERT | SAR search, CMP_WAIT cycles per bit, MSB first
// ST_PUBLISH | hands result to the output register, picks next channel
module tt_analog_scan_ctrl
    import tt_analog_pkg::*;
#(
    parameter int NCH        = tt_analog_pkg::NCH,
    parameter int NBITS      = tt_analog_pkg::NBITS,
    parameter int SETTLE_CYC = tt_analog_pkg::SETTLE_CYC,
    parameter int CMP_WAIT   = tt_analog_pkg::CMP_WAIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             cmp_in,
    output logic [CH_W-1:0]  mux_sel,
    output logic             mux_en,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH_W-1:0]  res_ch,
    output logic [NBITS-1:0] res_data
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int WW = (CMP_WAIT > 1)   ? $clog2(CMP_WAIT)   : 1;
    localparam int BW = (NBITS > 1)      ? $clog2(NBITS)      : 1;

    scan_state_t      state_q, state_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d, bit_dn;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [NBITS-1:0] code_d;
    logic             res_valid_d;
    logic [CH_W-1:0]  res_ch_d;
    logic [NBITS-1:0] res_data_d;

    logic             cmp_sync;
    logic             first_found, next_found;
    logic [CH_W-1:0]  first_ch, next_ch;

    tt_analog_cmp_sync u_cmp_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmp_in   (cmp_in),
        .cmp_sync (cmp_sync)
    );

    // Lowest set bit of the live mask (scan start) and the next set bit of
    // the latched mask above the current channel (scan advance). Iterating
    // downward lets the lowest qualifying index win.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_found = 1'b1;
                next_ch    = CH_W'(i);
            end
        end
    end

    assign bit_dn = bit_idx_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        bit_idx_d    = bit_idx_q;
        ch_d         = ch_q;
        mask_d       = mask_q;
        code_d       = dac_code;
        res_valid_d  = res_valid;
        res_ch_d     = res_ch;
        res_data_d   = res_data;

        if (res_valid && res_ready) begin
            res_valid_d = 1'b0;
        end

        if (abort || !ena) begin
            state_d = ST_IDLE;
            code_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && first_found) begin
                        mask_d       = ch_mask;
                        ch_d         = first_ch;
                        settle_cnt_d = SW'(SETTLE_CYC - 1);
                        code_d       = '0;
                        state_d      = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    code_d            = '0;
                    code_d[NBITS - 1] = 1'b1;
                    bit_idx_d         = BW'(NBITS - 1);
                    wait_cnt_d        = WW'(CMP_WAIT - 1);
                    state_d           = ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end else begin
                        // Terminal count: the synchronizer now reflects this trial.
                        if (!cmp_sync) begin
                            code_d[bit_idx_q] = 1'b0;
                        end
                        wait_cnt_d = WW'(CMP_WAIT - 1);
                        if (bit_idx_q == '0) begin
                            state_d = ST_PUBLISH;
                        end else begin
                            bit_idx_d      = bit_dn;
                            code_d[bit_dn] = 1'b1;
                        end
                    end
                end
                ST_PUBLISH: begin
                    // Stall with dac_code and mux held until the slot is free.
                    if (!res_valid || res_ready) begin
                        res_valid_d  = 1'b1;
                        res_ch_d     = ch_q;
                        res_data_d   = dac_code;
                        code_d       = '0;
                        settle_cnt_d = SW'(SETTLE_CYC - 1);
                        if (next_found) begin
                            ch_d    = next_ch;
                            state_d = ST_SETTLE;
                        end else if (continuous && first_found) begin
                            mask_d  = ch_mask;
                            ch_d    = first_ch;
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    code_d  = '0;
                end
            endcase
        end
    end

    // Mux/track/busy outputs are registered from the next state so they line
    // up with the state register rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            wait_cnt_q   <= '0;
            bit_idx_q    <= '0;
            ch_q         <= '0;
            mask_q       <= '0;
            dac_code     <= '0;
            res_valid    <= 1'b0;
            res_ch       <= '0;
            res_data     <= '0;
            busy         <= 1'b0;
            mux_en       <= 1'b0;
            sample       <= 1'b0;
            mux_sel      <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            bit_idx_q    <= bit_idx_d;
            ch_q         <= ch_d;
            mask_q       <= mask_d;
            dac_code     <= code_d;
            res_valid    <= res_valid_d;
            res_ch       <= res_ch_d;
            res_data     <= res_data_d;
            busy         <= (state_d != ST_IDLE);
            mux_en       <= (state_d != ST_IDLE);
            sample       <= (state_d == ST_SETTLE);
            mux_sel      <= ch_d;
        end
    end

endmodule

// File: tb/tb_tt_analog_scan_ctrl.sv
// Self-checking bench for tt_analog_scan_ctrl. An ideal comparator (vin >= dac)
// closes the loop; expectations come from the scan rules: ascending channel
// order, result equal to the channel's vin, fixed per-channel cycle count.
module tb_tt_analog_scan_ctrl;
    import tt_analog_pkg::*;

    localparam int CH_CYC = SETTLE_CYC + 1 + NBITS * CMP_WAIT + 1;

    logic             clk = 1'b0;
    logic             rst_n, ena, start, abort, continuous;
    logic [NCH-1:0]   ch_mask;
    logic             cmp_in;
    logic [CH_W-1:0]  mux_sel;
    logic             mux_en, sample, busy, res_valid, res_ready;
    logic [NBITS-1:0] dac_code, res_data;
    logic [CH_W-1:0]  res_ch;

    logic [NBITS-1:0] vin [8];
    logic [CH_W+NBITS-1:0] acc_q [$];
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    assign cmp_in = (vin[mux_sel] >= dac_code);

    always @(posedge clk) begin
        if (rst_n && res_valid && res_ready) acc_q.push_back({res_ch, res_data});
    end

    tt_analog_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .continuous(continuous), .ch_mask(ch_mask), .cmp_in(cmp_in),
        .mux_sel(mux_sel), .mux_en(mux_en), .sample(sample), .dac_code(dac_code),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_data(res_data)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Ideal binary search: first j decided bits equal vin, bit j under trial.
    function automatic int trial_code(input int v, input int j);
        int keep;
        keep = (v >> (NBITS - j)) << (NBITS - j);
        return keep | (1 << (NBITS - 1 - j));
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, ".busy"},     int'(busy),     0);
        check_val({tag, ".mux_en"},   int'(mux_en),   0);
        check_val({tag, ".sample"},   int'(sample),   0);
        check_val({tag, ".dac_code"}, int'(dac_code), 0);
    endtask

    task automatic scan_check(input logic [NCH-1:0] mask, input string tag);
        int chs[$];
        int nres, k, p, ch, v, j;
        for (int c = 0; c < NCH; c++) if (mask[c]) chs.push_back(c);
        nres = chs.size();
        res_ready = 1'b1;
        @(negedge clk);
        ch_mask = mask;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        ch_mask = NCH'($urandom);
        for (int n = 0; n <= CH_CYC * nres; n++) begin
            if (n > 0) @(negedge clk);
            k = n / CH_CYC;
            p = n % CH_CYC;
            if (n > 0 && p == 0) begin
                ch = chs[k - 1];
                check_val({tag, ".res_valid"}, int'(res_valid), 1);
                check_val({tag, ".res_ch"},    int'(res_ch),    ch);
                check_val({tag, ".res_data"},  int'(res_data),  int'(vin[ch]));
            end else if (p == CH_CYC - 1) begin
                check_val({tag, ".early_valid"}, int'(res_valid), 0);
            end
            if (k < nres) begin
                ch = chs[k];
                v  = int'(vin[ch]);
                if (p == 0) begin
                    check_val({tag, ".busy"},    int'(busy),    1);
                    check_val({tag, ".mux_en"},  int'(mux_en),  1);
                    check_val({tag, ".track"},   int'(sample),  1);
                    check_val({tag, ".mux_sel"}, int'(mux_sel), ch);
                end
                if (p == SETTLE_CYC) begin
                    check_val({tag, ".hold"},      int'(sample), 0);
                    check_val({tag, ".hold_mux"},  int'(mux_en), 1);
                end
                if (p > SETTLE_CYC && p < CH_CYC - 1 && (p - SETTLE_CYC - 1) % CMP_WAIT == 0) begin
                    j = (p - SETTLE_CYC - 1) / CMP_WAIT;
                    check_val({tag, ".trial"}, int'(dac_code), trial_code(v, j));
                end
                if (p == CH_CYC - 1) check_val({tag, ".final_code"}, int'(dac_code), v);
            end
        end
        @(negedge clk);
        check_idle_outputs({tag, ".end"});
        check_val({tag, ".cleared"}, int'(res_valid), 0);
    endtask

    task automatic test_backpressure();
        int a, b;
        logic [CH_W+NBITS-1:0] e;
        a = int'($urandom_range(4, 0));
        b = int'($urandom_range(5, a + 1));
        vin[a] = NBITS'($urandom);
        vin[b] = NBITS'($urandom);
        acc_q.delete();
        res_ready = 1'b0;
        ch_mask = NCH'((1 << a) | (1 << b));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= 2 * CH_CYC + 11; n++) begin
            if (n > 0) @(negedge clk);
            if (n == CH_CYC) begin
                check_val("bp.first_valid", int'(res_valid), 1);
                check_val("bp.first_data",  int'(res_data),  int'(vin[a]));
            end
            if (n >= 2 * CH_CYC - 1 && n <= 2 * CH_CYC + 9) begin
                check_val("bp.stall_valid", int'(res_valid), 1);
                check_val("bp.stall_ch",    int'(res_ch),    a);
                check_val("bp.stall_busy",  int'(busy),      1);
                check_val("bp.stall_mux",   int'(mux_en),    1);
                check_val("bp.stall_code",  int'(dac_code),  int'(vin[b]));
            end
            if (n == 2 * CH_CYC + 9) res_ready = 1'b1;
            if (n == 2 * CH_CYC + 10) begin
                check_val("bp.second_valid", int'(res_valid), 1);
                check_val("bp.second_ch",    int'(res_ch),    b);
                check_val("bp.second_data",  int'(res_data),  int'(vin[b]));
            end
            if (n == 2 * CH_CYC + 11) begin
                check_val("bp.done_valid", int'(res_valid), 0);
                check_val("bp.done_busy",  int'(busy),      0);
            end
        end
        check_val("bp.accepted", acc_q.size(), 2);
        e = {CH_W'(a), vin[a]};
        if (acc_q.size() > 0) check_val("bp.acc0", int'(acc_q[0]), int'(e));
        e = {CH_W'(b), vin[b]};
        if (acc_q.size() > 1) check_val("bp.acc1", int'(acc_q[1]), int'(e));
    endtask

    task automatic test_abort();
        int c;
        c = int'($urandom_range(5, 0));
        vin[c] = NBITS'($urandom);
        res_ready = 1'b0;
        ch_mask = NCH'(1 << c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (CH_CYC + 1) @(negedge clk);
        check_val("ab.prior_valid", int'(res_valid), 1);
        check_val("ab.prior_idle",  int'(busy),      0);
        ch_mask = NCH'($urandom_range(63, 1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("ab.convert");
        check_val("ab.keep_valid", int'(res_valid), 1);
        check_val("ab.keep_ch",    int'(res_ch),    c);
        check_val("ab.keep_data",  int'(res_data),  int'(vin[c]));
        repeat (2 * CH_CYC) @(negedge clk);
        check_val("ab.discarded_busy", int'(busy),     0);
        check_val("ab.discarded_data", int'(res_data), int'(vin[c]));
        // ena low behaves as abort
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        check_idle_outputs("ab.ena");
        // abort wins over start; zero mask and ena low ignore start
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check_val("ab.prio_busy", int'(busy), 0);
        ch_mask = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("ab.zero_mask_busy", int'(busy), 0);
        ch_mask = 6'b000001; ena = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ena = 1'b1;
        check_val("ab.no_ena_busy", int'(busy), 0);
        // synchronous reset mid-scan clears everything, including the held result
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst.mid");
        check_val("rst.res_valid", int'(res_valid), 0);
        check_val("rst.res_data",  int'(res_data),  0);
        check_val("rst.res_ch",    int'(res_ch),    0);
        check_val("rst.mux_sel",   int'(mux_sel),   0);
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        int m, exp_ch;
        for (int i = 0; i < 3; i++) vin[i] = NBITS'($urandom);
        res_ready  = 1'b1;
        continuous = 1'b1;
        ch_mask    = 6'b000011;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= 5 * CH_CYC + 1; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 2 * CH_CYC + 10) ch_mask = 6'b000100;
            if (n == 4 * CH_CYC + 5) continuous = 1'b0;
            if (n > 0 && n % CH_CYC == 0) begin
                m = n / CH_CYC;
                exp_ch = (m <= 4) ? (m - 1) % 2 : 2;
                check_val("cont.valid", int'(res_valid), 1);
                check_val("cont.ch",    int'(res_ch),    exp_ch);
                check_val("cont.data",  int'(res_data),  int'(vin[exp_ch]));
            end
            if (n == 4 * CH_CYC) check_val("cont.wrap_busy", int'(busy), 1);
            if (n == 5 * CH_CYC + 1) check_val("cont.stop_busy", int'(busy), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) vin[i] = '0;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
        continuous = 1'b0; ch_mask = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_val("reset.res_valid", int'(res_valid), 0);
        check_val("reset.res_ch",    int'(res_ch),    0);
        check_val("reset.res_data",  int'(res_data),  0);
        check_val("reset.mux_sel",   int'(mux_sel),   0);
        rst_n = 1'b1;
        @(negedge clk);

        vin[2] = 8'hA5; scan_check(6'b000100, "single");
        vin[2] = 8'h00; scan_check(6'b000100, "zero");
        vin[2] = 8'hFF; scan_check(6'b000100, "full");
        vin[0] = 8'h10; vin[3] = 8'h80; vin[5] = 8'hF0;
        scan_check(6'b101001, "multi");
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NCH; i++) vin[i] = NBITS'($urandom);
            scan_check(NCH'($urandom_range(63, 1)), "rand");
        end
        test_backpressure();
        test_abort();
        test_continuous();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
